// File: rtl/lcu_pkg.sv
// Shared defaults and sizing helpers for the queue-control unit.
package lcu_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 3;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/lcu_fifo_ctrl_if.sv
// Bundle of user requests, status outputs and the register-file port of the queue controller.
interface lcu_fifo_ctrl_if #(
    parameter int DATA_W = lcu_pkg::DEF_DATA_W,
    parameter int ADDR_W = lcu_pkg::DEF_ADDR_W
);
    localparam int DEPTH = lcu_pkg::depth_of(ADDR_W);

    logic              enq;
    logic              deq;
    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] out;
    logic              full;
    logic              emp;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] p;
    logic              ovf;
    logic              udf;
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    modport master (
        output enq, deq, in, rd,
        input  out, full, emp, almost_full, almost_empty, count, p, ovf, udf, valid,
               ra, we, wa, wd
    );

    modport slave (
        input  enq, deq, in, rd,
        output out, full, emp, almost_full, almost_empty, count, p, ovf, udf, valid,
               ra, we, wa, wd
    );

endinterface

// File: rtl/edge_pulse.sv
// Two-flop synchroniser followed by a rising-edge detector; one pulse per low-to-high transition.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic pulse_o
);

    logic sync_q;
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 1'b0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
        end else begin
            sync_q <= lvl_i;
            s1_q   <= sync_q;
            s2_q   <= s1_q;
        end
    end

    assign pulse_o = s1_q & ~s2_q;

endmodule

// File: rtl/lcu_fifo_ctrl.sv
// Circular-queue controller: pointers, occupancy, flags and slot bitmap for an external register file.
module lcu_fifo_ctrl
    import lcu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PULSE_IN = 1,
    parameter int AF_LVL   = 6,
    parameter int AE_LVL   = 1
) (
    input logic          clk,
    input logic          rst,
    lcu_fifo_ctrl_if.slave bus
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] FULL_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C   = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C   = AE_LVL[ADDR_W:0];

    logic              e_enq;
    logic              e_deq;
    logic              enq_acc;
    logic              deq_acc;
    logic              full;
    logic              emp;

    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    if (PULSE_IN != 0) begin : g_pulse
        edge_pulse u_enq_edge (.clk(clk), .rst(rst), .lvl_i(bus.enq), .pulse_o(e_enq));
        edge_pulse u_deq_edge (.clk(clk), .rst(rst), .lvl_i(bus.deq), .pulse_o(e_deq));
    end else begin : g_strobe
        assign e_enq = bus.enq;
        assign e_deq = bus.deq;
    end

    assign full = (count_q == FULL_C);
    assign emp  = (count_q == '0);

    // Gating with rst keeps the register file untouched during the reset cycle.
    assign enq_acc = rst & e_enq & ~full;
    assign deq_acc = rst & e_deq & ~emp;

    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        valid_d = valid_q;
        ovf_d   = e_enq & full;
        udf_d   = e_deq & emp;
        if (enq_acc) begin
            wp_d          = wp_q + 1'b1;
            valid_d[wp_q] = 1'b1;
        end
        if (deq_acc) begin
            rp_d          = rp_q + 1'b1;
            valid_d[rp_q] = 1'b0;
        end
        case ({enq_acc, deq_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.out          = bus.rd;
    assign bus.full         = full;
    assign bus.emp          = emp;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.p            = rp_q;
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;
    assign bus.valid        = valid_q;
    assign bus.ra           = rp_q;
    assign bus.we           = enq_acc;
    assign bus.wa           = wp_q;
    assign bus.wd           = bus.in;

endmodule

// File: tb/tb_lcu_fifo_ctrl.sv
// Bench for lcu_fifo_ctrl: strobe-mode instance against a queue model, level-mode instance for edge detection.
module tb_lcu_fifo_ctrl;

    logic clk;
    logic rst;

    lcu_fifo_ctrl_if #(.DATA_W(4), .ADDR_W(3)) f  ();
    lcu_fifo_ctrl_if #(.DATA_W(4), .ADDR_W(3)) f2 ();

    lcu_fifo_ctrl #(.DATA_W(4), .ADDR_W(3), .PULSE_IN(0), .AF_LVL(6), .AE_LVL(1))
        dut (.clk(clk), .rst(rst), .bus(f));
    lcu_fifo_ctrl #(.DATA_W(4), .ADDR_W(3), .PULSE_IN(1), .AF_LVL(6), .AE_LVL(1))
        dut2 (.clk(clk), .rst(rst), .bus(f2));

    logic [3:0] mem1 [8];
    logic [3:0] mem2 [8];

    assign f.rd  = mem1[f.ra];
    assign f2.rd = mem2[f2.ra];

    always @(posedge clk) begin
        if (f.we)  mem1[f.wa]  <= f.wd;
        if (f2.we) mem2[f2.wa] <= f2.wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] q [$];
    int  rp_m;
    int  wp_m;
    bit  ovf_m;
    bit  udf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_valid();
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < q.size(); k++) v[(rp_m + k) % 8] = 1'b1;
        return v;
    endfunction

    task automatic check_state();
        chk("count", 32'(f.count), 32'(q.size()));
        chk("emp", 32'(f.emp), 32'(q.size() == 0));
        chk("full", 32'(f.full), 32'(q.size() == 8));
        chk("almost_full", 32'(f.almost_full), 32'(q.size() >= 6));
        chk("almost_empty", 32'(f.almost_empty), 32'(q.size() <= 1));
        chk("p", 32'(f.p), 32'(rp_m));
        chk("ra", 32'(f.ra), 32'(rp_m));
        chk("wa", 32'(f.wa), 32'(wp_m));
        chk("ovf", 32'(f.ovf), 32'(ovf_m));
        chk("udf", 32'(f.udf), 32'(udf_m));
        chk("valid", 32'(f.valid), 32'(model_valid()));
        if (q.size() > 0) chk("out", 32'(f.out), 32'(q[0]));
    endtask

    task automatic step(input bit e, input bit d, input logic [3:0] din);
        bit full_m, emp_m, acc_e, acc_d;
        @(negedge clk);
        f.enq = e;
        f.deq = d;
        f.in  = din;
        #1;
        check_state();
        full_m = (q.size() == 8);
        emp_m  = (q.size() == 0);
        acc_e  = e && !full_m;
        acc_d  = d && !emp_m;
        chk("we", 32'(f.we), 32'(acc_e));
        if (acc_e) chk("wd", 32'(f.wd), 32'(din));
        ovf_m = e && full_m;
        udf_m = d && emp_m;
        if (acc_d) begin
            void'(q.pop_front());
            rp_m = (rp_m + 1) % 8;
        end
        if (acc_e) begin
            q.push_back(din);
            wp_m = (wp_m + 1) % 8;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        f.enq = 1'b1;
        f.deq = 1'b1;
        f.in  = 4'hA;
        #1;
        chk("we_in_reset", 32'(f.we), 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        f.enq = 1'b0;
        f.deq = 1'b0;
        q.delete();
        rp_m  = 0;
        wp_m  = 0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        #1;
        check_state();
        chk("we_after_reset", 32'(f.we), 32'd0);
    endtask

    initial begin
        rst    = 1'b0;
        f.enq  = 1'b0;
        f.deq  = 1'b0;
        f.in   = '0;
        f2.enq = 1'b0;
        f2.deq = 1'b0;
        f2.in  = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // single enqueue into an empty queue
        step(1, 0, 4'd5);
        step(0, 0, 4'd0);

        // fill to full, then one rejected enqueue
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, 0, 4'(i));
        step(1, 0, 4'd9);
        step(0, 0, 4'd0);

        // drain through the pointer wrap, then one rejected dequeue
        for (int i = 0; i < 8; i++) step(0, 1, 4'd0);
        step(0, 1, 4'd0);
        step(0, 0, 4'd0);

        // simultaneous requests with a partly filled queue and with an empty queue
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 4'(i + 3));
        step(1, 1, 4'hC);
        step(0, 0, 4'd0);
        do_reset();
        step(1, 1, 4'd7);
        step(0, 0, 4'd0);

        // simultaneous requests when full
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 4'(15 - i));
        step(1, 1, 4'd2);
        step(0, 0, 4'd0);

        // reset in the middle of traffic
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 4'(i));
        do_reset();

        // randomized traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
                     4'($urandom));
            end
        end
        step(0, 0, 4'd0);

        // level-mode instance: one accepted enqueue per rising edge, two cycles after the rise
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            f2.enq = 1'b1;
            f2.in  = 4'h6;
            #1;
            chk("pulse_we", 32'(f2.we), 32'(i == 2));
            if (i == 2) chk("pulse_wa", 32'(f2.wa), 32'd0);
        end
        @(negedge clk);
        f2.enq = 1'b0;
        #1;
        chk("pulse_count", 32'(f2.count), 32'd1);
        chk("pulse_valid", 32'(f2.valid), 32'h01);
        chk("pulse_out", 32'(f2.out), 32'h6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            f2.deq = 1'b1;
            #1;
            chk("pulse_udf", 32'(f2.udf), 32'd0);
        end
        @(negedge clk);
        f2.deq = 1'b0;
        #1;
        chk("pulse_drain_count", 32'(f2.count), 32'd0);
        chk("pulse_drain_p", 32'(f2.p), 32'd1);
        chk("pulse_drain_emp", 32'(f2.emp), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
